// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

    // Largest value representable in `digits` decimal digits (10^digits - 1).
    function automatic int max_value(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESHOLD) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with input saturation and a leading-zero blank mask for the display decoders.
//
//   state | meaning
//   IDLE  | waiting for start, outputs hold last result
//   SHIFT | converting, one bit per cycle for WIDTH cycles
//   DONE  | result registered this cycle, start here restarts immediately
module bin_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]             blank,
    output logic                          overflow
);

    localparam int BCD_W     = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W    = BCD_W + WIDTH;
    localparam int CNT_W     = $clog2(WIDTH + 1);
    localparam int MAX_VALUE = max_value(DIGITS);

    localparam logic [WIDTH-1:0]  MAX_BIN    = WIDTH'(MAX_VALUE);
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST  = ~DIGITS'(1);

    state_t             state;
    logic [WORK_W-1:0]  work_q;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;

    logic [BCD_W-1:0]   bcd_adj;
    logic [WORK_W-1:0]  work_next;
    logic [BCD_W-1:0]   bcd_next;
    logic [DIGITS-1:0]  blank_next;
    logic               ovf_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_add3 (
            .digit_in  (work_q[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign work_next = {bcd_adj, work_q[WIDTH-1:0]} << 1;
    assign bcd_next  = work_next[WORK_W-1:WIDTH];
    assign ovf_in    = 32'(bin_in) > $unsigned(MAX_VALUE);

    // A digit is blanked only if it and every more significant digit are zero.
    always_comb begin
        logic all_zero;
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (bcd_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_next[i] = all_zero;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            work_q   <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        work_q   <= {{BCD_W{1'b0}}, (ovf_in ? MAX_BIN : bin_in)};
                        ovf_pend <= ovf_in;
                        cnt      <= LAST_SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= work_next;
                    if (cnt == '0) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd_out  <= bcd_next;
                        blank    <= blank_next;
                        overflow <= ovf_pend;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed self-checking bench for bin_to_bcd_serial with hand-computed results.
module tb_bin_to_bcd_serial;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic [3:0]  blank;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_cnt;

    bin_to_bcd_serial #(.WIDTH(14), .DIGITS(4)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .blank    (blank),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [13:0] v);
        @(posedge clock);
        #1;
        bin_in = v;
        start  = 1'b1;
    endtask

    // Counts edges until done is seen; start is dropped after the first edge.
    task automatic wait_done(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            n++;
            if (done) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    task automatic count_idle_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        check("rst_bcd",      32'(bcd_out),  32'h0000);
        check("rst_blank",    32'(blank),    32'b1110);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        count_idle_done(20, done_cnt);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // 1234
        launch(14'd1234);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(lat);
        check("lat_1234",   32'(lat + 1),  32'd15);
        check("bcd_1234",   32'(bcd_out),  32'h1234);
        check("blank_1234", 32'(blank),    32'b0000);
        check("ovf_1234",   32'(overflow), 32'd0);
        check("busy_in_done", 32'(busy),   32'd0);
        @(posedge clock);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);

        // 7 then 9999 back-to-back
        launch(14'd7);
        wait_done(lat);
        check("lat_7",   32'(lat),     32'd15);
        check("bcd_7",   32'(bcd_out), 32'h0007);
        check("blank_7", 32'(blank),   32'b1110);
        bin_in = 14'd9999;
        start  = 1'b1;
        wait_done(lat);
        check("lat_b2b",     32'(lat),      32'd15);
        check("bcd_9999",    32'(bcd_out),  32'h9999);
        check("ovf_9999",    32'(overflow), 32'd0);
        check("blank_9999",  32'(blank),    32'b0000);

        // saturation then a normal value
        launch(14'd16383);
        wait_done(lat);
        check("lat_16383", 32'(lat),      32'd15);
        check("bcd_16383", 32'(bcd_out),  32'h9999);
        check("ovf_16383", 32'(overflow), 32'd1);
        launch(14'd42);
        wait_done(lat);
        check("bcd_42",   32'(bcd_out),  32'h0042);
        check("blank_42", 32'(blank),    32'b1100);
        check("ovf_42",   32'(overflow), 32'd0);

        launch(14'd0);
        wait_done(lat);
        check("bcd_0",   32'(bcd_out),  32'h0000);
        check("blank_0", 32'(blank),    32'b1110);
        check("ovf_0",   32'(overflow), 32'd0);

        launch(14'd10000);
        wait_done(lat);
        check("bcd_10000", 32'(bcd_out),  32'h9999);
        check("ovf_10000", 32'(overflow), 32'd1);

        // start re-asserted with a different value while busy
        launch(14'd300);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        start  = 1'b1;
        bin_in = 14'd5;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        check("held_bcd_busy", 32'(bcd_out),  32'h9999);
        check("held_ovf_busy", 32'(overflow), 32'd1);
        wait_done(lat);
        check("lat_300",   32'(lat),      32'd10);
        check("bcd_300",   32'(bcd_out),  32'h0300);
        check("blank_300", 32'(blank),    32'b1000);
        check("ovf_300",   32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        check("no_restart_300", 32'(busy), 32'd0);

        // reset mid-conversion
        launch(14'd8888);
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_busy",  32'(busy),    32'd0);
        check("abort_done",  32'(done),    32'd0);
        check("abort_bcd",   32'(bcd_out), 32'h0000);
        check("abort_blank", 32'(blank),   32'b1110);
        @(negedge clock);
        resetn = 1'b1;
        count_idle_done(20, done_cnt);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        launch(14'd8888);
        wait_done(lat);
        check("lat_8888",   32'(lat),      32'd15);
        check("bcd_8888",   32'(bcd_out),  32'h8888);
        check("blank_8888", 32'(blank),    32'b0000);
        check("ovf_8888",   32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_serial.md
# bin_to_bcd_serial

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the per-digit decimal-to-seven-segment decoders. It takes the binary reaction-time result in milliseconds and produces packed BCD digits plus a leading-zero blank mask. Out-of-range inputs saturate to all nines and raise an overflow flag.

## Interface
Parameters:
- WIDTH, 14: binary input width in bits.
- DIGITS, 4: number of BCD output digits. MAX_VALUE = 10^DIGITS − 1 = 9999.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion of bin_in. Sampled only in IDLE or DONE.
- bin_in  in  WIDTH  unsigned binary value, captured on the accepted start edge.
- busy  out  1  high while converting (SHIFT state).
- done  out  1  one-cycle pulse; bcd_out, blank and overflow are valid from this cycle.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]. Held until the next done.
- blank  out  DIGITS  per-digit leading-zero mask, 1 = consumer drives segments off. blank[0] is always 0.
- overflow  out  1  captured input exceeded MAX_VALUE. Held with bcd_out.

## Operation
- States: IDLE → SHIFT → DONE → IDLE.
  - IDLE to SHIFT on start.
  - SHIFT to DONE after WIDTH shift cycles.
  - DONE to SHIFT if start is high in DONE (back-to-back), otherwise DONE to IDLE.
- Capture on accepted start:
  - If bin_in > MAX_VALUE, load MAX_VALUE and set the pending overflow to 1.
  - Otherwise load bin_in and set the pending overflow to 0.
- Working register: {bcd[4*DIGITS-1:0], bin[WIDTH-1:0]}, with bcd cleared at capture. Shift cycle counter is ceil(log2(WIDTH+1)) bits, 0..WIDTH−1.
- Each SHIFT cycle, in order:
  - Every BCD digit ≥ 5 gets +3 (4-bit add, no carry out).
  - The whole register then shifts left by 1.
- Entering DONE: bcd_out, blank and overflow are loaded from the working register and the pending flag.
- blank[i] = 1 iff digit i and all higher digits are 0, for i ≥ 1.
- start while busy is ignored. No queueing; bin_in is not re-sampled.
- Outputs never show intermediate values. They change only on the DONE entry edge or on reset.

## Timing
- start high at edge k in IDLE:
  - busy = 1 for edges k+1 .. k+WIDTH.
  - done = 1 at edge k+WIDTH+1, which is 15 cycles for the default WIDTH.
- Back-to-back: start during the DONE cycle gives busy at the next edge. The minimum period is WIDTH+1 cycles.
- Reset values:
  - state IDLE, busy 0, done 0, overflow 0.
  - bcd_out 0.
  - blank = all ones except bit 0 (4'b1110).
- Reset asserted mid-conversion aborts it immediately and asynchronously. No done pulse follows. Outputs take their reset values.
- Input boundaries:
  - bin_in = 0 gives 0000, blank 1110.
  - bin_in = MAX_VALUE gives 9999, overflow 0.
  - bin_in = MAX_VALUE+1 or greater (up to 2^WIDTH−1) gives 9999, overflow 1.

## Structure
- Shared package bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD_DIGIT_W = 4
  - ADD3_THRESHOLD = 5
  - the MAX_VALUE function of DIGITS
- Sub-module bcd_add3_cell: combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times via generate.
- Top level holds the FSM, counter, working register, output registers and blank logic.

## Test plan
- Reset then idle: bcd_out 0000, blank 1110, overflow 0, busy 0, done never pulses.
- start with bin_in = 1234: done exactly 15 cycles later, bcd_out = 16'h1234, blank 0000, overflow 0.
- bin_in = 7 then bin_in = 9999, back-to-back:
  - First result 16'h0007, blank 1110.
  - Second start issued in the DONE cycle; second done 15 cycles after the first, giving 16'h9999.
- bin_in = 16383: bcd_out 16'h9999, overflow 1. A following conversion of 42 gives 16'h0042, blank 1100, overflow 0.
- start re-asserted with bin_in = 5 during busy of a 300 conversion: ignored; result 16'h0300, blank 1000.
- resetn pulsed low at cycle 6 of a conversion of 8888: no done; outputs at reset values; a new start of 8888 gives 16'h8888.
